// File: rtl/word_byte_serializer.sv
// Serializes a packed word of byte lanes into a byte stream, first byte the cycle after acceptance.
// Holds out_byte/out_last stable under out_ready=0; in_ready rises combinationally on the accepted last beat.
module word_byte_serializer #(
  parameter int NUM_BYTES = 4,
  parameter int BYTE_W    = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16,
  localparam int WORD_W   = NUM_BYTES * BYTE_W,
  localparam int LEN_W    = $clog2(NUM_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [LEN_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              busy,
  output logic              err_len,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [WORD_W-1:0]   word_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    index;
  logic                accept;
  logic                in_legal;
  logic                last_fire;

  function automatic logic [BYTE_W-1:0] pick(input logic [WORD_W-1:0] w, input int k);
    return w[k*BYTE_W +: BYTE_W];
  endfunction

  // Lane order flips for MSB_FIRST; only lanes below len are ever selected.
  function automatic int lane_of(input int len, input int idx);
    return (MSB_FIRST != 0) ? (len - 1 - idx) : idx;
  endfunction

  assign last_fire = (state == SEND) && out_valid && out_ready && out_last;
  assign in_ready  = (state == IDLE) || last_fire;
  assign accept    = in_valid && in_ready;
  assign in_legal  = (in_len != '0) && (int'(in_len) <= NUM_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_q    <= '0;
      len_q     <= '0;
      index     <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      err_len <= 1'b0;
      if (last_fire) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (accept) begin
        if (in_legal) begin
          state     <= SEND;
          word_q    <= in_word;
          len_q     <= in_len;
          index     <= '0;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          out_byte  <= pick(in_word, lane_of(int'(in_len), 0));
          out_last  <= (int'(in_len) == 1);
        end else begin
          state     <= IDLE;
          err_len   <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (state == SEND && out_ready) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          index    <= index + 1'b1;
          out_byte <= pick(word_q, lane_of(int'(len_q), int'(index) + 1));
          out_last <= (int'(index) + 2 == int'(len_q));
        end
      end
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench: LSB-first instance for most steps, MSB-first instance for lane-order check.
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, err_len;
  logic [31:0] in_word;
  logic [2:0]  in_len;
  logic [7:0]  out_byte;
  logic [15:0] frame_cnt;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last, m_busy, m_err_len;
  logic [31:0] m_in_word;
  logic [2:0]  m_in_len;
  logic [7:0]  m_out_byte;
  logic [15:0] m_frame_cnt;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  word_byte_serializer #(.NUM_BYTES(4), .BYTE_W(8), .MSB_FIRST(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_len(in_len), .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .busy(busy), .err_len(err_len), .frame_cnt(frame_cnt));

  word_byte_serializer #(.NUM_BYTES(4), .BYTE_W(8), .MSB_FIRST(1), .CNT_W(16)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_word(m_in_word),
    .in_len(m_in_len), .out_valid(m_out_valid), .out_ready(m_out_ready), .out_byte(m_out_byte),
    .out_last(m_out_last), .busy(m_busy), .err_len(m_err_len), .frame_cnt(m_frame_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_b [8];
    rst_n = 1'b0;
    in_valid = 0; in_word = '0; in_len = '0; out_ready = 1;
    m_in_valid = 0; m_in_word = '0; m_in_len = '0; m_out_ready = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // LSB-first, len 4
    in_valid = 1; in_word = 32'h44332211; in_len = 3'd4;
    tick();
    in_valid = 0;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w1_valid%0d", k), out_valid, 1);
      chk($sformatf("w1_byte%0d", k), out_byte, exp_b[k]);
      chk($sformatf("w1_last%0d", k), out_last, (k == 3));
      chk($sformatf("w1_busy%0d", k), busy, 1);
      tick();
    end
    chk("w1_idle_valid", out_valid, 0);
    chk("w1_frame_cnt", frame_cnt, 1);
    chk("w1_busy_end", busy, 0);

    // MSB-first, len 3
    m_in_valid = 1; m_in_word = 32'h44332211; m_in_len = 3'd3;
    tick();
    m_in_valid = 0;
    exp_b[0] = 8'h33; exp_b[1] = 8'h22; exp_b[2] = 8'h11;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("msb_valid%0d", k), m_out_valid, 1);
      chk($sformatf("msb_byte%0d", k), m_out_byte, exp_b[k]);
      chk($sformatf("msb_last%0d", k), m_out_last, (k == 2));
      tick();
    end
    chk("msb_idle_valid", m_out_valid, 0);
    chk("msb_frame_cnt", m_frame_cnt, 1);

    // Back-to-back words, no bubble
    in_valid = 1; in_word = 32'h44332211; in_len = 3'd4;
    tick();
    in_word = 32'h88776655;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    exp_b[4] = 8'h55; exp_b[5] = 8'h66; exp_b[6] = 8'h77; exp_b[7] = 8'h88;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_valid%0d", k), out_valid, 1);
      chk($sformatf("b2b_byte%0d", k), out_byte, exp_b[k]);
      chk($sformatf("b2b_last%0d", k), out_last, (k == 3 || k == 7));
      chk($sformatf("b2b_in_ready%0d", k), in_ready, (k == 3 || k == 7));
      tick();
      if (k == 3) in_valid = 0;
    end
    chk("b2b_idle_valid", out_valid, 0);
    chk("b2b_frame_cnt", frame_cnt, 3);

    // Stall on byte 22
    in_valid = 1; in_word = 32'h44332211; in_len = 3'd4;
    tick();
    in_valid = 0;
    chk("stall_b0", out_byte, 8'h11);
    tick();
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall_byte%0d", k), out_byte, 8'h22);
      chk($sformatf("stall_valid%0d", k), out_valid, 1);
      chk($sformatf("stall_in_ready%0d", k), in_ready, 0);
      chk($sformatf("stall_last%0d", k), out_last, 0);
      tick();
    end
    out_ready = 1;
    exp_b[0] = 8'h22; exp_b[1] = 8'h33; exp_b[2] = 8'h44;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_resume%0d", k), out_byte, exp_b[k]);
      tick();
    end
    chk("stall_frame_cnt", frame_cnt, 4);

    // Illegal lengths 0 and 5
    in_valid = 1; in_word = 32'hDEADBEEF; in_len = 3'd0;
    tick();
    in_len = 3'd5;
    chk("err0_pulse", err_len, 1);
    chk("err0_valid", out_valid, 0);
    tick();
    in_valid = 0;
    chk("err5_pulse", err_len, 1);
    chk("err5_valid", out_valid, 0);
    tick();
    chk("err_clear", err_len, 0);
    chk("err_valid_after", out_valid, 0);
    chk("err_frame_cnt", frame_cnt, 4);

    // Single-byte word
    in_valid = 1; in_word = 32'h000000A5; in_len = 3'd1;
    tick();
    in_valid = 0;
    chk("len1_byte", out_byte, 8'hA5);
    chk("len1_last", out_last, 1);
    chk("len1_in_ready", in_ready, 1);
    tick();
    chk("len1_idle", out_valid, 0);
    chk("len1_frame_cnt", frame_cnt, 5);

    // Reset mid-word after byte 22
    in_valid = 1; in_word = 32'h44332211; in_len = 3'd4;
    tick();
    in_valid = 0;
    tick();
    chk("mid_b22", out_byte, 8'h22);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_byte", out_byte, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_rst_valid%0d", k), out_valid, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
